// File: rtl/uart_rx.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module   : uart_rx                                                        |
// | Purpose  : 8N1 serial receiver. Resynchronizes the asynchronous rx line,  |
// |            detects the start bit, samples each bit at mid-bit with an     |
// |            internal baud counter and presents the received byte with a    |
// |            one-cycle strobe, plus a framing-error strobe.                 |
// | Ports    : clk   - system clock                                           |
// |            rst   - synchronous reset, active-high                         |
// |            rx    - serial line, asynchronous, idle high                   |
// |            data  - last received byte (LSB received first)                |
// |            rcv   - one-cycle pulse, data is valid and new                 |
// |            ferr  - one-cycle pulse, stop bit sampled low                  |
// |            perr  - one-cycle pulse, parity mismatch                       |
// | Options  : define UART_RX_PARITY_EN to insert an even-parity bit between  |
// |            the data bits and the stop bit. Without it perr is tied to 0.  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_rx #(
    parameter int unsigned BAUD = 104   // clock cycles per bit, 4..65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       perr
);

    localparam int unsigned CNT_W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             rcv_q;
    logic             ferr_q;
    logic             tick;

`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             perr_q;
`endif

    // The counter idles at zero, so a tick is simply "counter reached zero".
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            rcv_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;

            // Strobes default low; they are only raised for a single cycle.
            rcv_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif

            if (!tick) begin
                cnt_q <= cnt_q - C_ONE;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= C_HALF;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            cnt_q     <= C_FULL;
                            bit_idx_q <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        // LSB arrives first, so shift in at the MSB end.
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        cnt_q     <= C_FULL;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        // Even parity: XOR of data bits must equal the parity bit.
                        par_bad_q <= (^shift_q) ^ rx_s_q;
                        cnt_q     <= C_FULL;
                        state_q   <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (tick) begin
                        if (rx_s_q) begin
                            data_q <= shift_q;
                            rcv_q  <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        perr_q <= par_bad_q;
`endif
                        // Back to IDLE at mid-stop so a following start edge
                        // is never missed.
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data = data_q;
    assign rcv  = rcv_q;
    assign ferr = ferr_q;

`ifdef UART_RX_PARITY_EN
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                     |
// | Purpose  : Directed self-checking bench for uart_rx (8N1 receiver).       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

    localparam int BAUD = 104;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EXTRA = BAUD;
`else
    localparam int PAR_EXTRA = 0;
`endif
    // rx driven low at cycle c: 2 sync cycles, BAUD/2 to mid-start,
    // 9*BAUD to mid-stop, plus one cycle for the registered strobe.
    localparam int RCV_LAT = 2 + BAUD / 2 + 9 * BAUD + 1 + PAR_EXTRA;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       perr;

    int n_checks;
    int n_fail;
    int cyc;
    int rcv_cnt;
    int ferr_cnt;
    int both_cnt;
    int rcv_cyc;
    int start_cyc;
    logic [7:0] last_data;
    logic       last_perr;
    logic [7:0] data_hist [$];

    uart_rx #(.BAUD(BAUD)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr),
        .perr (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rcv) begin
            rcv_cnt   = rcv_cnt + 1;
            rcv_cyc   = cyc;
            last_data = data;
            last_perr = perr;
            data_hist.push_back(data);
        end
        if (ferr) ferr_cnt = ferr_cnt + 1;
        if (rcv && ferr) both_cnt = both_cnt + 1;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the line at the stop level at a negedge,
    // so consecutive calls produce frames with no idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        rx        = 1'b0;
        start_cyc = cyc;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        repeat (BAUD) @(negedge clk);
`else
        if (par_bit) rx = 1'b1;   // parity bit unused in the 8N1 build
`endif
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
    endtask

    initial begin
        int base_rcv;
        int base_ferr;
        logic [7:0] frame;

        n_checks  = 0;
        n_fail    = 0;
        rcv_cnt   = 0;
        ferr_cnt  = 0;
        both_cnt  = 0;
        rcv_cyc   = 0;
        start_cyc = 0;
        last_data = 8'h00;
        last_perr = 1'b0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_rcv",  {31'd0, rcv},  32'h0);
        check("reset_ferr", {31'd0, ferr}, 32'h0);
        check("reset_perr", {31'd0, perr}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0x4B with exact strobe timing.
        frame = 8'h4B;
        send_frame(frame, 1'b1, ^frame);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("4b_rcv_cnt",  rcv_cnt, 1);
        check("4b_data",     {24'd0, last_data}, 32'h4B);
        check("4b_ferr_cnt", ferr_cnt, 0);
        check("4b_latency",  rcv_cyc - start_cyc, RCV_LAT);
        check("4b_data_hold", {24'd0, data}, 32'h4B);

        // Back-to-back frames with no idle gap.
        frame = 8'h00; send_frame(frame, 1'b1, ^frame);
        frame = 8'hFF; send_frame(frame, 1'b1, ^frame);
        frame = 8'hA5; send_frame(frame, 1'b1, ^frame);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b_rcv_cnt",  rcv_cnt, 4);
        check("b2b_ferr_cnt", ferr_cnt, 0);
        check("b2b_d0", {24'd0, data_hist[1]}, 32'h00);
        check("b2b_d1", {24'd0, data_hist[2]}, 32'hFF);
        check("b2b_d2", {24'd0, data_hist[3]}, 32'hA5);

        // Framing error: stop bit driven low.
        frame = 8'h3C;
        send_frame(frame, 1'b0, ^frame);
        rx = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("ferr_cnt",     ferr_cnt, 1);
        check("ferr_rcv_cnt", rcv_cnt, 4);
        check("ferr_data",    {24'd0, data}, 32'hA5);

        // Start-bit glitch shorter than half a bit.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("glitch_rcv_cnt",  rcv_cnt, 4);
        check("glitch_ferr_cnt", ferr_cnt, 1);
        frame = 8'h55;
        send_frame(frame, 1'b1, ^frame);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_next_rcv",  rcv_cnt, 5);
        check("glitch_next_data", {24'd0, last_data}, 32'h55);

        // Reset in the middle of data bit 4.
        base_rcv  = rcv_cnt;
        base_ferr = ferr_cnt;
        frame = 8'hF0;
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = frame[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = frame[4];
        repeat (BAUD / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        check("abort_data_reset", {24'd0, data}, 32'h00);
        repeat (12 * BAUD) @(negedge clk);
        check("abort_rcv_cnt",  rcv_cnt, base_rcv);
        check("abort_ferr_cnt", ferr_cnt, base_ferr);
        check("abort_data",     {24'd0, data}, 32'h00);
        frame = 8'h81;
        send_frame(frame, 1'b1, ^frame);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("after_abort_rcv",  rcv_cnt, base_rcv + 1);
        check("after_abort_data", {24'd0, last_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even-parity bit is 1.
        send_frame(8'h07, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("par_ok_rcv",  rcv_cnt, base_rcv + 2);
        check("par_ok_perr", {31'd0, last_perr}, 32'h0);
        send_frame(8'h07, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("par_bad_rcv",  rcv_cnt, base_rcv + 3);
        check("par_bad_perr", {31'd0, last_perr}, 32'h1);
        check("par_bad_data", {24'd0, last_data}, 32'h07);
`endif

        check("rcv_ferr_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
